btb_port_arb: RTL
=================

BTB_PORT_ARB -- requirements
Module: btb_port_arb

Interface
REQ-001 Parameter ENTRY_NUM, default 8: number of BTB entries; power of two, at least 2.
REQ-002 Parameter IDX_W, default 3: entry index width, equal to log2(ENTRY_NUM).
REQ-003 Parameter STARVE_MAX, default 3: consecutive denied cycles with a full FIFO before an update preempts lookup.
REQ-004 Port clk, input, 1: single clock; all state on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port hold_i, input, 1: pipeline hold; 1 means no fetch lookup this cycle.
REQ-007 Port lk_req_i, input, 1: fetch requests the table port for a read.
REQ-008 Port lk_grant_o, output, 1: lookup owns the port this cycle.
REQ-009 Port upd_valid_i, input, 1: EX-stage BTB update offered.
REQ-010 Ports upd_pc_i and upd_target_i, input, 32 each: branch PC and branch target.
REQ-011 Port upd_idx_i, input, IDX_W: entry index for the update.
REQ-012 Port upd_taken_i, input, 1: resolved direction of the branch.
REQ-013 Port upd_ready_o, output, 1: update FIFO can accept an update.
REQ-014 Port flush_req_i, input, 1: request to invalidate all entries.
REQ-015 Port flush_busy_o, output, 1: flush sequence is in progress.
REQ-016 Ports tbl_we_o (1), tbl_idx_o (IDX_W), tbl_pc_o (32), tbl_target_o (32), tbl_taken_o (1), tbl_valid_o (1), all outputs: table write port.

Function
REQ-017 The block SHALL contain a 2-entry update FIFO; a push occurs when upd_valid_i and upd_ready_o are both 1.
REQ-018 upd_ready_o SHALL equal (FIFO not full) and (state is not FLUSH).
- Readiness is evaluated from the state at cycle start.
- A pop in the same cycle SHALL NOT make room for a push in that cycle.
REQ-019 The block SHALL implement the FSM states IDLE and FLUSH.
REQ-020 In IDLE, port arbitration SHALL follow this order:
- Starvation win: if the starve counter equals STARVE_MAX and the FIFO is non-empty, the update wins.
- Otherwise, if lk_req_i is 1 and hold_i is 0, the lookup wins.
- Otherwise, if the FIFO is non-empty, the update wins.
- Otherwise, the port is idle.
REQ-021 When the update wins, the block SHALL drive for that cycle:
- tbl_we_o=1 and tbl_valid_o=1.
- tbl_idx_o, tbl_pc_o, tbl_target_o and tbl_taken_o from the FIFO head.
- It SHALL pop the head at the clock edge.
REQ-022 Write outputs SHALL be combinational from state and FIFO head; an update pushed in cycle N SHALL be written no earlier than cycle N+1.
REQ-023 The starve counter SHALL behave as follows:
- Increment, saturating at STARVE_MAX, each cycle the FIFO is full and the lookup wins.
- Clear on every update write.
REQ-024 When the update wins by starvation, lk_grant_o SHALL be 0 even if lk_req_i is 1.
REQ-025 FIFO ordering SHALL be preserved; updates to the same index SHALL be written in push order.
REQ-026 flush_req_i=1 in IDLE SHALL cause the following at that edge:
- Enter FLUSH.
- Clear the FIFO, discarding pending updates.
- Clear the starve counter.
- Clear the flush index.
REQ-027 In FLUSH, each cycle the block SHALL:
- Drive tbl_we_o=1, tbl_valid_o=0 and tbl_idx_o equal to the flush index.
- Drive tbl_pc_o, tbl_target_o and tbl_taken_o as 0.
- Hold lk_grant_o=0.
- Increment the flush index.
REQ-028 After writing index ENTRY_NUM-1, the block SHALL return to IDLE; FLUSH lasts exactly ENTRY_NUM cycles.
REQ-029 flush_busy_o SHALL be 1 exactly while in FLUSH; flush_req_i during FLUSH SHALL be ignored.
REQ-030 Simultaneous flush_req_i and upd push in IDLE: the flush SHALL take effect and the pushed update SHALL be discarded.
REQ-031 When none of the above applies, the block SHALL drive tbl_we_o=0, and all tbl_* data outputs SHALL be 0.

Reset
REQ-032 rst_n low SHALL immediately and asynchronously set:
- FSM to IDLE.
- FIFO empty.
- Starve counter 0 and flush index 0.
REQ-033 During and after reset, outputs SHALL be:
- lk_grant_o=0, tbl_we_o=0, flush_busy_o=0, all tbl_* data outputs 0.
- upd_ready_o=1 once rst_n is high.
REQ-034 Reset asserted mid-flush SHALL abort the flush with no further writes.

Configuration
REQ-035 Macro BTB_FLUSH_SEQ_EN compiles in the flush sequencer.
- When defined, the block SHALL behave as in REQ-026 to REQ-030.
- When undefined, FLUSH SHALL be absent, flush_req_i SHALL be ignored, and flush_busy_o SHALL be tied to 0.

Verification
REQ-036 Idle port: push pc=0x80000010, target 0x80000100, idx 2, taken=1 -> next cycle tbl_we_o=1, tbl_idx_o=2, tbl_valid_o=1, tbl_taken_o=1.
REQ-037 Lookup priority: lk_req_i=1, hold_i=0 every cycle, two updates pushed -> upd_ready_o=0 after the second push.
- After 3 full-FIFO cycles, lk_grant_o=0 for one cycle and the first update is written.
REQ-038 Hold: hold_i=1 with lk_req_i=1 and FIFO non-empty -> lk_grant_o=0 and the update is written the same cycle.
REQ-039 Flush (ENTRY_NUM=8): FIFO holds 2 updates and flush_req_i is pulsed.
- flush_busy_o=1 for 8 cycles; tbl_idx_o goes 0..7 with tbl_valid_o=0.
- The pending updates are never written; upd_ready_o=1 after the flush.
REQ-040 Simultaneous flush and push -> the pushed update is never written.
REQ-041 Async reset asserted at flush index 4 -> tbl_we_o=0 immediately and the next write requires a new push.

Source files
------------

// File: rtl/btb_port_arb.sv
// BTB table-port arbiter: shares the single table port between fetch lookups,
// a 2-entry EX-update FIFO and, when BTB_FLUSH_SEQ_EN is defined, a flush sequencer.

module btb_port_arb #(
  parameter int ENTRY_NUM  = 8,
  parameter int IDX_W      = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             lk_req_i,
  output logic             lk_grant_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic [31:0]      upd_target_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  output logic             upd_ready_o,
  input  logic             flush_req_i,
  output logic             flush_busy_o,
  output logic             tbl_we_o,
  output logic [IDX_W-1:0] tbl_idx_o,
  output logic [31:0]      tbl_pc_o,
  output logic [31:0]      tbl_target_o,
  output logic             tbl_taken_o,
  output logic             tbl_valid_o
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      pc;
    logic [31:0]      target;
    logic             taken;
  } upd_t;

  upd_t             fifo_q [2];
  upd_t             head;
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic [CNT_W-1:0] starve_q;
  logic [IDX_W-1:0] flush_idx_q;
  logic             in_flush;
  logic             flush_start;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_full    = (count_q == 2'd2);
  assign fifo_empty   = (count_q == 2'd0);
  assign head         = fifo_q[rd_ptr_q];
  assign upd_ready_o  = rst_n && !fifo_full && !in_flush;
  assign push         = upd_valid_i && upd_ready_o;
  assign flush_busy_o = in_flush;

`ifdef BTB_FLUSH_SEQ_EN
  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] flush_idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    flush_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
          flush_start = 1'b1;
        end
      end
      FLUSH: begin
        flush_idx_d = flush_idx_q + 1'b1;
        if (flush_idx_q == IDX_W'(ENTRY_NUM - 1)) state_d = IDLE;
      end
    endcase
  end

  assign in_flush = (state_q == FLUSH);
`else
  logic unused_cfg;

  assign unused_cfg  = flush_req_i ^ (ENTRY_NUM == 0);
  assign in_flush    = 1'b0;
  assign flush_start = 1'b0;
  assign flush_idx_q = '0;
`endif

  // A flush request in IDLE also suppresses that cycle's update write, so
  // nothing queued before the flush ever reaches the table.
  always_comb begin
    lk_grant_o   = 1'b0;
    tbl_we_o     = 1'b0;
    tbl_valid_o  = 1'b0;
    tbl_idx_o    = '0;
    tbl_pc_o     = '0;
    tbl_target_o = '0;
    tbl_taken_o  = 1'b0;
    pop          = 1'b0;
    if (rst_n) begin
      if (in_flush) begin
        tbl_we_o  = 1'b1;
        tbl_idx_o = flush_idx_q;
      end else if (starve_q == STARVE_LIM && !fifo_empty && !flush_start) begin
        pop = 1'b1;
      end else if (lk_req_i && !hold_i) begin
        lk_grant_o = 1'b1;
      end else if (!fifo_empty && !flush_start) begin
        pop = 1'b1;
      end
      if (pop) begin
        tbl_we_o     = 1'b1;
        tbl_valid_o  = 1'b1;
        tbl_idx_o    = head.idx;
        tbl_pc_o     = head.pc;
        tbl_target_o = head.target;
        tbl_taken_o  = head.taken;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else if (flush_start) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{idx: upd_idx_i, pc: upd_pc_i, target: upd_target_i, taken: upd_taken_i};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Only cycles where a full FIFO loses to a lookup count toward starvation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (flush_start || pop) begin
      starve_q <= '0;
    end else if (fifo_full && lk_grant_o && starve_q != STARVE_LIM) begin
      starve_q <= starve_q + 1'b1;
    end
  end

endmodule
